// File: rtl/cu_pkg.sv
// ============================================================================
// cu_pkg -- MIPS-I opcode/funct/ALU-code constants for the control/mux unit.
// Rev 1.0
// ============================================================================
`default_nettype none

package cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;
  localparam logic [3:0] ALU_LUI = 4'hA;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_R31 = 2'b10,
    RD_RSV = 2'b11
  } regdst_e;

endpackage

`default_nettype wire

// File: rtl/cu_mux_unit_mux2.sv
// ============================================================================
// mux2 -- DW-wide 2:1 multiplexer; y = b when sel is high, else a.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux2 #(
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/cu_mux_unit.sv
// ============================================================================
// cu_mux_unit -- MIPS-I main decoder plus datapath muxes and sticky illegal flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module cu_mux_unit
  import cu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] imm_ext,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] pc_plus4,
  input  logic [DW-1:0] branch_target,
  input  logic [DW-1:0] jump_target,
  input  logic          zero,
  output logic [1:0]    regdst,
  output logic          jump,
  output logic          regwr,
  output logic          alusrc,
  output logic          memrd,
  output logic          memwr,
  output logic          memtoreg,
  output logic          branch,
  output logic          bne,
  output logic [3:0]    aluop,
  output logic [4:0]    waddr,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] next_pc,
  output logic          illegal
);

  logic [5:0]    op;
  logic [5:0]    funct;
  regdst_e       regdst_sel;
  logic          illegal_det;
  logic          illegal_d;
  logic          illegal_q;
  logic          take;
  logic [DW-1:0] pc_mux;
  logic          unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  // Legal encodings clear illegal_det; anything falling through leaves all strobes low.
  always_comb begin
    regdst_sel  = RD_RT;
    jump        = 1'b0;
    regwr       = 1'b0;
    alusrc      = 1'b0;
    memrd       = 1'b0;
    memwr       = 1'b0;
    memtoreg    = 1'b0;
    branch      = 1'b0;
    bne         = 1'b0;
    aluop       = ALU_ADD;
    illegal_det = 1'b0;
    case (op)
      OP_RTYPE: begin
        regdst_sel = RD_RD;
        regwr      = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: aluop = ALU_ADD;
          FN_SUB, FN_SUBU: aluop = ALU_SUB;
          FN_AND:          aluop = ALU_AND;
          FN_OR:           aluop = ALU_OR;
          FN_XOR:          aluop = ALU_XOR;
          FN_NOR:          aluop = ALU_NOR;
          FN_SLT:          aluop = ALU_SLT;
          FN_SLL:          aluop = ALU_SLL;
          FN_SRL:          aluop = ALU_SRL;
          FN_SRA:          aluop = ALU_SRA;
          default: begin
            regdst_sel  = RD_RT;
            regwr       = 1'b0;
            illegal_det = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        alusrc = 1'b1;
        regwr  = 1'b1;
        case (op)
          OP_SLTI: aluop = ALU_SLT;
          OP_ANDI: aluop = ALU_AND;
          OP_ORI:  aluop = ALU_OR;
          OP_LUI:  aluop = ALU_LUI;
          default: aluop = ALU_ADD;
        endcase
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memrd    = 1'b1;
        memtoreg = 1'b1;
        regwr    = 1'b1;
      end
      OP_SW: begin
        alusrc = 1'b1;
        memwr  = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = ALU_SUB;
      end
      OP_BNE: begin
        bne   = 1'b1;
        aluop = ALU_SUB;
      end
      OP_J: jump = 1'b1;
      OP_JAL: begin
        jump       = 1'b1;
        regwr      = 1'b1;
        regdst_sel = RD_R31;
      end
      default: illegal_det = 1'b1;
    endcase
  end

  assign regdst = regdst_sel;

  always_comb begin
    waddr = 5'd0;
    case (regdst_sel)
      RD_RT:   waddr = instr[20:16];
      RD_RD:   waddr = instr[15:11];
      RD_R31:  waddr = 5'd31;
      default: waddr = 5'd0;
    endcase
  end

  assign take  = (branch & zero) | (bne & ~zero);
  assign wdata = (regdst_sel == RD_R31) ? pc_plus4 :
                 memtoreg               ? mem_rdata : alu_result;

  mux2 #(.DW(DW)) u_mux_alu_b (.sel(alusrc), .a(rdata2),   .b(imm_ext),       .y(alu_b));
  mux2 #(.DW(DW)) u_mux_pc    (.sel(take),   .a(pc_plus4), .b(branch_target), .y(pc_mux));
  mux2 #(.DW(DW)) u_mux_next  (.sel(jump),   .a(pc_mux),   .b(jump_target),   .y(next_pc));

  always_comb begin
    illegal_d = illegal_q | illegal_det;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cu_mux_unit.sv
// ============================================================================
// tb_cu_mux_unit -- directed vector table, sticky-flag sequence and random model check.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cu_mux_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic [DW-1:0] rdata2, imm_ext, alu_result, mem_rdata;
  logic [DW-1:0] pc_plus4, branch_target, jump_target;
  logic          zero;
  logic [1:0]    regdst;
  logic          jump, regwr, alusrc, memrd, memwr, memtoreg, branch, bne;
  logic [3:0]    aluop;
  logic [4:0]    waddr;
  logic [DW-1:0] alu_b, wdata, next_pc;
  logic          illegal;

  always #5 clk = ~clk;

  cu_mux_unit #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .rdata2(rdata2), .imm_ext(imm_ext), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .pc_plus4(pc_plus4), .branch_target(branch_target), .jump_target(jump_target),
    .zero(zero), .regdst(regdst), .jump(jump), .regwr(regwr), .alusrc(alusrc),
    .memrd(memrd), .memwr(memwr), .memtoreg(memtoreg), .branch(branch), .bne(bne),
    .aluop(aluop), .waddr(waddr), .alu_b(alu_b), .wdata(wdata), .next_pc(next_pc),
    .illegal(illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Control word: {regdst[1:0], jump, regwr, alusrc, memrd, memwr, memtoreg, branch, bne, aluop[3:0]}
  // Lookup tables: bit 14 marks a legal encoding.
  logic [14:0] op_tbl [64];
  logic [14:0] fn_tbl [64];

  function automatic logic [14:0] mk(input logic [1:0] rd, input logic [7:0] s, input logic [3:0] a);
    return {1'b1, rd, s, a};
  endfunction

  task automatic build_tables();
    for (int i = 0; i < 64; i++) begin
      op_tbl[i] = '0;
      fn_tbl[i] = '0;
    end
    fn_tbl[6'h20] = mk(2'b01, 8'b01000000, 4'd0);
    fn_tbl[6'h21] = mk(2'b01, 8'b01000000, 4'd0);
    fn_tbl[6'h22] = mk(2'b01, 8'b01000000, 4'd1);
    fn_tbl[6'h23] = mk(2'b01, 8'b01000000, 4'd1);
    fn_tbl[6'h24] = mk(2'b01, 8'b01000000, 4'd2);
    fn_tbl[6'h25] = mk(2'b01, 8'b01000000, 4'd3);
    fn_tbl[6'h26] = mk(2'b01, 8'b01000000, 4'd4);
    fn_tbl[6'h27] = mk(2'b01, 8'b01000000, 4'd5);
    fn_tbl[6'h2A] = mk(2'b01, 8'b01000000, 4'd6);
    fn_tbl[6'h00] = mk(2'b01, 8'b01000000, 4'd7);
    fn_tbl[6'h02] = mk(2'b01, 8'b01000000, 4'd8);
    fn_tbl[6'h03] = mk(2'b01, 8'b01000000, 4'd9);
    op_tbl[6'h08] = mk(2'b00, 8'b01100000, 4'd0);
    op_tbl[6'h09] = mk(2'b00, 8'b01100000, 4'd0);
    op_tbl[6'h0A] = mk(2'b00, 8'b01100000, 4'd6);
    op_tbl[6'h0C] = mk(2'b00, 8'b01100000, 4'd2);
    op_tbl[6'h0D] = mk(2'b00, 8'b01100000, 4'd3);
    op_tbl[6'h0F] = mk(2'b00, 8'b01100000, 4'd10);
    op_tbl[6'h23] = mk(2'b00, 8'b01110100, 4'd0);
    op_tbl[6'h2B] = mk(2'b00, 8'b00101000, 4'd0);
    op_tbl[6'h04] = mk(2'b00, 8'b00000010, 4'd1);
    op_tbl[6'h05] = mk(2'b00, 8'b00000001, 4'd1);
    op_tbl[6'h02] = mk(2'b00, 8'b10000000, 4'd0);
    op_tbl[6'h03] = mk(2'b10, 8'b11000000, 4'd0);
  endtask

  function automatic logic [14:0] lookup(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    return (op == 6'd0) ? fn_tbl[fn] : op_tbl[op];
  endfunction

  function automatic logic [13:0] dut_ctl();
    return {regdst, jump, regwr, alusrc, memrd, memwr, memtoreg, branch, bne, aluop};
  endfunction

  logic exp_ill = 1'b0;

  // Drive instr/zero/rst, check comb outputs, clock once, check sticky flag.
  task automatic step_and_check(input logic [13:0] ctl, input logic [4:0] wa,
                                input logic [DW-1:0] eb, input logic [DW-1:0] ew,
                                input logic [DW-1:0] ep, input logic legal);
    #1;
    chk("ctl", {50'd0, dut_ctl()}, {50'd0, ctl});
    chk("waddr", {59'd0, waddr}, {59'd0, wa});
    chk("alu_b", {32'd0, alu_b}, {32'd0, eb});
    chk("wdata", {32'd0, wdata}, {32'd0, ew});
    chk("next_pc", {32'd0, next_pc}, {32'd0, ep});
    @(posedge clk);
    exp_ill = rst ? 1'b0 : (exp_ill | ~legal);
    #1;
    chk("illegal", {63'd0, illegal}, {63'd0, exp_ill});
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic [13:0] ctl;
    logic [4:0]  wa;
    int          bsel;   // 0 rdata2, 1 imm_ext
    int          wsel;   // 0 alu_result, 1 mem_rdata, 2 pc_plus4
    int          psel;   // 0 pc_plus4, 1 branch_target, 2 jump_target
    logic        legal;
  } vec_t;

  vec_t vt [15];

  function automatic logic [DW-1:0] pick_b(input int s);
    return (s == 1) ? imm_ext : rdata2;
  endfunction
  function automatic logic [DW-1:0] pick_w(input int s);
    return (s == 2) ? pc_plus4 : (s == 1) ? mem_rdata : alu_result;
  endfunction
  function automatic logic [DW-1:0] pick_p(input int s);
    return (s == 2) ? jump_target : (s == 1) ? branch_target : pc_plus4;
  endfunction

  initial begin
    build_tables();
    vt[0]  = '{32'h00221820, 1'b0, {2'b01, 8'b01000000, 4'h0}, 5'd3,  0, 0, 0, 1'b1};
    vt[1]  = '{32'h8C220004, 1'b0, {2'b00, 8'b01110100, 4'h0}, 5'd2,  1, 1, 0, 1'b1};
    vt[2]  = '{32'h1022FFFF, 1'b1, {2'b00, 8'b00000010, 4'h1}, 5'd2,  0, 0, 1, 1'b1};
    vt[3]  = '{32'h1022FFFF, 1'b0, {2'b00, 8'b00000010, 4'h1}, 5'd2,  0, 0, 0, 1'b1};
    vt[4]  = '{32'h14220003, 1'b0, {2'b00, 8'b00000001, 4'h1}, 5'd2,  0, 0, 1, 1'b1};
    vt[5]  = '{32'h14220003, 1'b1, {2'b00, 8'b00000001, 4'h1}, 5'd2,  0, 0, 0, 1'b1};
    vt[6]  = '{32'h08000010, 1'b0, {2'b00, 8'b10000000, 4'h0}, 5'd0,  0, 0, 2, 1'b1};
    vt[7]  = '{32'h0C000010, 1'b0, {2'b10, 8'b11000000, 4'h0}, 5'd31, 0, 2, 2, 1'b1};
    vt[8]  = '{32'hAC220008, 1'b1, {2'b00, 8'b00101000, 4'h0}, 5'd2,  1, 0, 0, 1'b1};
    vt[9]  = '{32'h3C011234, 1'b0, {2'b00, 8'b01100000, 4'hA}, 5'd1,  1, 0, 0, 1'b1};
    vt[10] = '{32'h00021843, 1'b0, {2'b01, 8'b01000000, 4'h9}, 5'd3,  0, 0, 0, 1'b1};
    vt[11] = '{32'h00000000, 1'b1, {2'b01, 8'b01000000, 4'h7}, 5'd0,  0, 0, 0, 1'b1};
    vt[12] = '{32'h28220005, 1'b0, {2'b00, 8'b01100000, 4'h6}, 5'd2,  1, 0, 0, 1'b1};
    vt[13] = '{32'h00000008, 1'b1, {2'b00, 8'b00000000, 4'h0}, 5'd0,  0, 0, 0, 1'b0};
    vt[14] = '{32'hFC000000, 1'b1, {2'b00, 8'b00000000, 4'h0}, 5'd0,  0, 0, 0, 1'b0};

    rdata2 = 32'h1111_1111; imm_ext = 32'h2222_2222; alu_result = 32'h3333_3333;
    mem_rdata = 32'h4444_4444; pc_plus4 = 32'h0000_1004; branch_target = 32'h0000_2000;
    jump_target = 32'h0000_0040; zero = 1'b0; instr = 32'h0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_illegal", {63'd0, illegal}, 64'd0);
    rst = 1'b0;

    // Directed table; the illegal entries sit at the end so the sticky model is exercised.
    for (int i = 0; i < 15; i++) begin
      instr = vt[i].ins;
      zero  = vt[i].z;
      step_and_check(vt[i].ctl, vt[i].wa, pick_b(vt[i].bsel), pick_w(vt[i].wsel),
                     pick_p(vt[i].psel), vt[i].legal);
    end

    // Sticky flag: set, hold through legal nop, reset wins over a simultaneous illegal.
    rst = 1'b1; instr = 32'h0; @(posedge clk); #1; rst = 1'b0; exp_ill = 1'b0;
    chk("seq_clear0", {63'd0, illegal}, 64'd0);
    instr = 32'hFC000000; @(posedge clk); #1;
    chk("seq_set", {63'd0, illegal}, 64'd1);
    instr = 32'h0; @(posedge clk); #1;
    chk("seq_hold", {63'd0, illegal}, 64'd1);
    rst = 1'b1; instr = 32'hFC000000; @(posedge clk); #1;
    chk("seq_rst_prio", {63'd0, illegal}, 64'd0);
    rst = 1'b0; instr = 32'h0; @(posedge clk); #1;
    chk("seq_stay0", {63'd0, illegal}, 64'd0);
    exp_ill = 1'b0;

    // Random stimulus against the table-driven model.
    for (int n = 0; n < 400; n++) begin
      logic [14:0] e;
      logic [4:0]  wa;
      logic        tk;
      logic [5:0]  legal_ops [13];
      legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                    6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
      instr = $urandom;
      if ($urandom_range(0, 3) != 0)
        instr[31:26] = legal_ops[$urandom_range(0, 12)];
      if (instr[31:26] == 6'h00 && $urandom_range(0, 2) != 0)
        instr[5:0] = 6'($urandom_range(0, 11)) + ((($urandom_range(0, 1)) != 0) ? 6'h20 : 6'h00);
      zero = 1'($urandom);
      rst  = ($urandom_range(0, 19) == 0);
      rdata2 = $urandom; imm_ext = $urandom; alu_result = $urandom; mem_rdata = $urandom;
      pc_plus4 = $urandom; branch_target = $urandom; jump_target = $urandom;
      e  = lookup(instr);
      wa = (e[13:12] == 2'b00) ? instr[20:16] : (e[13:12] == 2'b01) ? instr[15:11] :
           (e[13:12] == 2'b10) ? 5'd31 : 5'd0;
      tk = (e[5] & zero) | (e[4] & ~zero);
      step_and_check(e[13:0], wa,
                     e[9] ? imm_ext : rdata2,
                     (e[13:12] == 2'b10) ? pc_plus4 : (e[6] ? mem_rdata : alu_result),
                     e[11] ? jump_target : (tk ? branch_target : pc_plus4),
                     e[14]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cu_mux_unit.md
CU_MUX_UNIT -- requirements
Module: cu_mux_unit

Interface
REQ-001 Parameter: DW, default 32, datapath width of all data muxes.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 instr  in  32  current instruction, MIPS-I encoding.
REQ-006 rdata2, imm_ext, alu_result, mem_rdata  in  DW each  RF port-2 data, sign-extended immediate, ALU result, data-memory read data.
REQ-007 pc_plus4, branch_target, jump_target  in  DW each  next-PC candidates.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 regdst  out  2  write-register select: 00 rt, 01 rd, 10 r31, 11 reserved.
REQ-010 jump, regwr, alusrc, memrd, memwr, memtoreg, branch, bne  out  1 each  control strobes.
REQ-011 aluop  out  4  ALU code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 sra, 1010 lui.
REQ-012 waddr  out  5  selected RF write address.
REQ-013 alu_b, wdata, next_pc  out  DW each  ALU B operand, RF write data, next PC.
REQ-014 illegal  out  1  sticky registered illegal-instruction flag.

Function
REQ-015 All outputs except illegal SHALL be combinational from current inputs (zero cycles latency).
REQ-016 R-type (op 0x00) SHALL set regdst=01, regwr=1; funct 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl, 0x03 sra.
REQ-017 addi/addiu (0x08/0x09) add, slti 0x0A slt, andi 0x0C and, ori 0x0D or, lui 0x0F lui: each SHALL set regdst=00, alusrc=1, regwr=1.
REQ-018 lw (0x23) SHALL set alusrc=1, memrd=1, memtoreg=1, regwr=1, regdst=00, aluop add.
REQ-019 sw (0x2B) SHALL set alusrc=1, memwr=1, aluop add, regwr=0.
REQ-020 beq (0x04) SHALL set branch=1; bne (0x05) SHALL set bne=1; both aluop sub, regwr=0.
REQ-021 j (0x02) SHALL set jump=1; jal (0x03) SHALL set jump=1, regwr=1, regdst=10.
REQ-022 Any strobe not listed for an instruction SHALL be 0; regdst default 00, aluop default 0000.
REQ-023 Unlisted opcode or R-type funct SHALL drive all strobes 0, regdst 00, aluop 0000.
REQ-024 waddr SHALL be instr[20:16] (00), instr[15:11] (01), 31 (10), 0 (11).
REQ-025 alu_b SHALL be imm_ext when alusrc=1, else rdata2.
REQ-026 wdata SHALL be pc_plus4 when regdst=10, else mem_rdata when memtoreg=1, else alu_result.
REQ-027 take = (branch & zero) | (bne & ~zero); pc_mux SHALL be branch_target if take, else pc_plus4.
REQ-028 next_pc SHALL be jump_target when jump=1, else pc_mux.
REQ-029 illegal SHALL set to 1 on the first rising edge with an illegal instruction and hold until reset.
REQ-030 instr 0x00000000 (sll nop) SHALL be legal.

Reset
REQ-031 rst=1 at a rising edge SHALL clear illegal to 0; rst SHALL take priority over a simultaneous illegal instruction.
REQ-032 Combinational outputs SHALL NOT depend on rst.

Structure
REQ-033 Opcode, funct and aluop encodings SHALL be constants in a shared package cu_pkg.
REQ-034 A single sub-module mux2 (DW-wide 2:1) SHALL be used for alu_b, pc_mux and next_pc.
REQ-035 Decode SHALL be one combinational case block; the write-address select SHALL be inline 4:1 logic.

Verification
REQ-036 instr=0x00221820 -> regdst=01, regwr=1, aluop=0000, waddr=3, alu_b=rdata2, wdata=alu_result.
REQ-037 instr=0x8C220004 -> alusrc=1, memrd=1, memtoreg=1, waddr=2, alu_b=imm_ext, wdata=mem_rdata.
REQ-038 instr=0x1022FFFF with zero=1 -> next_pc=branch_target; with zero=0 -> pc_plus4. instr=0x14220003 with zero=0 -> branch_target.
REQ-039 instr=0x08000010 -> next_pc=jump_target, regwr=0. instr=0x0C000010 -> waddr=31, wdata=pc_plus4, regwr=1.
REQ-040 instr=0xFC000000 -> all strobes 0 and illegal=1 after the next edge; then instr=0 -> illegal stays 1; then rst=1 for one edge -> illegal=0.
